mem_copy_engine: RTL and testbench

Command-side initiator for the `mem_cmd_t` SRAM command interface: it accepts block requests and drives `sram_cmd`'s `cmd` input while consuming its `rdata`. It performs either a word-by-word copy (read source, write destination) or a constant fill. It replaces bench-style hand-driven command sequences so other logic can move or clear memory regions with one handshake.

---
 rtl/mem_pkg.sv | 36 +++
 rtl/sram_cmd.sv | 25 ++
 rtl/mem_copy_engine.sv | 97 +++++++++
 tb/tb_mem_copy_engine.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the SRAM command interface and the
// block copy/fill engine that drives it.
package mem_pkg;

  localparam int ADDR_W  = 4;
  localparam int DATA_W  = 8;
  localparam int LEN_W   = 5;
  localparam int MAX_LEN = 16;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_cmd_t;

  typedef struct packed {
    logic              fill;
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;
    logic [LEN_W-1:0]  len;
    logic [DATA_W-1:0] pattern;
  } copy_req_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_DONE
  } copy_state_e;

  // Requests longer than the largest legal block are cut down to it.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    return (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
  endfunction

endpackage

// File: rtl/sram_cmd.sv
// Single-port SRAM behind the mem_cmd_t interface: writes on we, and
// returns the addressed word one cycle after the command is presented.
module sram_cmd
  import mem_pkg::*;
(
  input  logic              clk,
  input  mem_cmd_t          cmd,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_rdata;

  // NOTE: the storage array has no reset; clearing a RAM costs a write
  // port per word and real SRAM macros cannot do it anyway.
  always_ff @(posedge clk) begin
    if (cmd.we) begin
      r_mem[cmd.addr] <= cmd.wdata;
    end
    r_rdata <= r_mem[cmd.addr];
  end

  assign rdata = r_rdata;

endmodule

// File: rtl/mem_copy_engine.sv
// Block mover for the SRAM command port: copies src..src+len-1 to
// dst..dst+len-1 word by word, or fills the destination with a constant.
module mem_copy_engine
  import mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_fill,
  input  logic [ADDR_W-1:0] req_src,
  input  logic [ADDR_W-1:0] req_dst,
  input  logic [LEN_W-1:0]  req_len,
  input  logic [DATA_W-1:0] req_pattern,
  output logic              busy,
  output logic              done,
  output mem_cmd_t          cmd,
  input  logic [DATA_W-1:0] rdata
);

  copy_state_e      r_state;
  copy_state_e      w_next_state;
  copy_req_t        r_req;
  logic [LEN_W-1:0] r_idx;
  logic [LEN_W-1:0] w_idx_inc;
  logic             w_accept;
  logic             w_last;

  assign w_accept  = req_valid && (r_state == ST_IDLE);
  assign w_idx_inc = r_idx + LEN_W'(1);
  assign w_last    = !(w_idx_inc < r_req.len);

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_req   <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_req.fill    <= req_fill;
        r_req.src     <= req_src;
        r_req.dst     <= req_dst;
        r_req.len     <= clamp_len(req_len);
        r_req.pattern <= req_pattern;
        r_idx         <= '0;
      end else if (r_state == ST_WR && !w_last) begin
        r_idx <= w_idx_inc;
      end
    end
  end

  // NOTE: the default assignment first keeps this block purely
  // combinational; a branch that skipped it would infer a latch.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          if (clamp_len(req_len) == '0) w_next_state = ST_DONE;
          else if (req_fill)            w_next_state = ST_WR;
          else                          w_next_state = ST_RD;
        end
      end
      ST_RD:   w_next_state = ST_WR;
      ST_WR: begin
        if (w_last)          w_next_state = ST_DONE;
        else if (!r_req.fill) w_next_state = ST_RD;
      end
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Addresses truncate to ADDR_W bits, so blocks wrap around the top of memory.
  always_comb begin
    cmd = '0;
    unique case (r_state)
      ST_RD: begin
        cmd.addr = r_req.src + r_idx[ADDR_W-1:0];
      end
      ST_WR: begin
        cmd.we    = 1'b1;
        cmd.addr  = r_req.dst + r_idx[ADDR_W-1:0];
        cmd.wdata = r_req.fill ? r_req.pattern : rdata;
      end
      default: cmd = '0;
    endcase
  end

  assign req_ready = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_DONE);

endmodule

// File: tb/tb_mem_copy_engine.sv
// Scoreboard bench for mem_copy_engine + sram_cmd: a sequential-loop memory
// model predicts every write (cycle, address, data) and every done pulse.
module tb_mem_copy_engine;
  import mem_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_fill = 1'b0;
  logic [ADDR_W-1:0] req_src = '0;
  logic [ADDR_W-1:0] req_dst = '0;
  logic [LEN_W-1:0]  req_len = '0;
  logic [DATA_W-1:0] req_pattern = '0;
  logic              busy;
  logic              done;
  mem_cmd_t          cmd;
  logic [DATA_W-1:0] w_rdata;

  mem_copy_engine u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_fill(req_fill), .req_src(req_src), .req_dst(req_dst),
    .req_len(req_len), .req_pattern(req_pattern), .busy(busy), .done(done),
    .cmd(cmd), .rdata(w_rdata)
  );

  sram_cmd u_sram (.clk(clk), .cmd(cmd), .rdata(w_rdata));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int                cyc;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t               wq[$];
  int                dq[$];
  logic [DATA_W-1:0] model [16];
  int                n_tests = 0;
  int                n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every write and every done pulse must match the head of its queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (cmd.we) begin
        if (wq.size() == 0) begin
          check("unexpected_write", 32'(wq.size()), 32'd1);
        end else begin
          wr_t e;
          e = wq.pop_front();
          check("wr_cycle", cyc, e.cyc);
          check("wr_addr", 32'(cmd.addr), 32'(e.addr));
          check("wr_data", 32'(cmd.wdata), 32'(e.data));
        end
      end
      if (done) begin
        if (dq.size() == 0) check("unexpected_done", 32'(dq.size()), 32'd1);
        else                check("done_cycle", cyc, dq.pop_front());
      end
    end
  end

  // Offers one request when ready and predicts its effect as the plain loop
  // "for i < len: mem[dst+i] = fill ? pattern : mem[src+i]". n_model limits
  // how many words are predicted (used when the block is cut short by reset).
  task automatic issue(input bit fill, input int src, input int dst, input int len,
                       input int pat, output int acc, output int exp_ready,
                       input int n_model = 99);
    int k = 0;
    int l;
    @(negedge clk);
    while (!req_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("ready_before_issue", 32'(req_ready), 32'd1);
    req_valid   = 1'b1;
    req_fill    = fill;
    req_src     = ADDR_W'(src);
    req_dst     = ADDR_W'(dst);
    req_len     = LEN_W'(len);
    req_pattern = DATA_W'(pat);
    acc = cyc;
    l = (len > 16) ? 16 : len;
    for (int i = 0; i < l && i < n_model; i++) begin
      wr_t e;
      e.addr = ADDR_W'(dst + i);
      e.data = fill ? DATA_W'(pat) : model[(src + i) % 16];
      e.cyc  = fill ? acc + 1 + i : acc + 2 + 2 * i;
      model[e.addr] = e.data;
      wq.push_back(e);
    end
    exp_ready = (fill ? acc + l : acc + 2 * l) + 2;
    if (n_model >= l) dq.push_back(exp_ready - 1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_ready(input int exp_ready);
    int k = 0;
    while (!req_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("ready_cycle", cyc, exp_ready);
  endtask

  task automatic run(input bit fill, input int src, input int dst, input int len, input int pat);
    int a, r;
    issue(fill, src, dst, len, pat, a, r);
    wait_ready(r);
  endtask

  initial begin
    int a, r, a2, k;
    for (int i = 0; i < 16; i++) model[i] = 'x;

    // Reset held for two cycles.
    repeat (2) @(negedge clk);
    check("rst_cmd", 32'(cmd), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    #1 rst = 1'b0;

    // Clear the whole memory, then preload and copy.
    run(1'b1, 0, 0, 16, 0);
    run(1'b1, 0, 3, 1, 55);
    run(1'b1, 0, 4, 1, 66);
    run(1'b0, 3, 10, 2, 0);
    check("copy_mem10", 32'(u_sram.r_mem[10]), 32'd55);
    check("copy_mem11", 32'(u_sram.r_mem[11]), 32'd66);

    // Fill wrapping from 15 to 0; word 2 must stay untouched.
    run(1'b1, 0, 14, 4, 8'hA5);
    check("wrap_mem14", 32'(u_sram.r_mem[14]), 32'hA5);
    check("wrap_mem15", 32'(u_sram.r_mem[15]), 32'hA5);
    check("wrap_mem0", 32'(u_sram.r_mem[0]), 32'hA5);
    check("wrap_mem1", 32'(u_sram.r_mem[1]), 32'hA5);
    check("wrap_mem2", 32'(u_sram.r_mem[2]), 32'h00);

    // Zero length: done at A+1, ready at A+2, no writes.
    run(1'b0, 5, 6, 0, 0);

    // Overlapping forward copy propagates the first word.
    for (int i = 0; i < 4; i++) run(1'b1, 0, i, 1, i + 1);
    run(1'b0, 0, 1, 3, 0);
    check("ovl_mem1", 32'(u_sram.r_mem[1]), 32'd1);
    check("ovl_mem2", 32'(u_sram.r_mem[2]), 32'd1);
    check("ovl_mem3", 32'(u_sram.r_mem[3]), 32'd1);

    // Request held valid with new fields while busy: taken only in IDLE.
    issue(1'b0, 8, 12, 3, 0, a, r);
    req_valid = 1'b1; req_fill = 1'b1; req_dst = 4'd5; req_len = 5'd2; req_pattern = 8'h3C;
    k = 0;
    while (!req_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    a2 = cyc;
    check("held_accept_cycle", a2, a + 2 * 3 + 2);
    for (int i = 0; i < 2; i++) begin
      wr_t e;
      e.addr = ADDR_W'(5 + i); e.data = 8'h3C; e.cyc = a2 + 1 + i;
      model[e.addr] = e.data;
      wq.push_back(e);
    end
    dq.push_back(a2 + 3);
    @(negedge clk);
    req_valid = 1'b0;
    wait_ready(a2 + 4);

    // Reset right after the first write of a 3-word copy.
    issue(1'b0, 2, 9, 3, 0, a, r, 1);
    @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("midrst_cmd", 32'(cmd), 32'd0);
    check("midrst_ready", 32'(req_ready), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);

    // Length above 16 is clamped.
    run(1'b1, 0, 7, 20, 8'h5A);

    // Randomised copies and fills.
    for (int t = 0; t < 30; t++) begin
      run(1'($urandom), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
          int'($urandom_range(0, 20)), int'($urandom_range(0, 255)));
    end

    repeat (3) @(negedge clk);
    check("wq_empty", 32'(wq.size()), 32'd0);
    check("dq_empty", 32'(dq.size()), 32'd0);
    for (int i = 0; i < 16; i++) check("final_mem", 32'(u_sram.r_mem[i]), 32'(model[i]));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
